iwdt_feed_sched: RTL
====================

# iwdt_feed_sched

Register-side sequencer that shares the independent watchdog (IWDT) register port between several software or hardware requesters. It sits between the requesters and the IWDT register block, driving that block's `addr`/`write_en`/`wdata`/`byte_strobe` inputs in place of the APB slave interface. For each granted request it runs the locked-register write sequence: unlock, then reload or interrupt-clear, then relock. It also enforces an optional feed window against the live counter value.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `LOCK_ADDR`, 32'h0000_0C00: byte address of the IWDT lock register.
- `LOAD_ADDR`, 32'h0000_0000: byte address of the IWDT load register.
- `INTCLR_ADDR`, 32'h0000_000C: byte address of the IWDT interrupt-clear register.
- `UNLOCK_KEY`, 32'h1ACC_E551: value written to `LOCK_ADDR` to unlock.
- `LOCK_KEY`, 32'h0000_0000: value written to `LOCK_ADDR` to relock.

Ports:
- `pclk`, in, 1: the only clock; all logic is on its rising edge.
- `prestn`, in, 1: reset, synchronous and active-high (1 = reset).
- `req`, in, NREQ: level request per requester.
- `req_clr`, in, NREQ: operation type per requester; 1 = interrupt clear, 0 = feed (reload).
- `reload_val`, in, 32: load value, shared by all requesters; sampled at grant.
- `win_en`, in, 1: enables window checking of feeds.
- `win_limit`, in, 32: a feed is legal only when `iwdt_value` <= `win_limit`.
- `iwdt_value`, in, 32: current IWDT down-counter value.
- `addr`, out, 32: register address to the IWDT register block.
- `write_en`, out, 1: one-cycle write strobe.
- `wdata`, out, 32: write data.
- `byte_strobe`, out, 4: byte enables; 4'hF during a write, else 0.
- `gnt`, out, NREQ: one-hot, one-cycle completion pulse.
- `err`, out, NREQ: one-hot; pulses together with `gnt` when a feed is rejected.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- State machine states: IDLE, UNLOCK, OP, LOCK, DONE.
- **IDLE.** If any `req` bit is set, pick a winner by round-robin, starting the search at pointer `ptr`. Latch the winner index, `req_clr[idx]` and `reload_val`.
  - Window reject: if the request is a feed (`req_clr[idx]` = 0), `win_en` = 1 and `iwdt_value` > `win_limit` (unsigned compare, sampled in this cycle), the request is rejected. Go to DONE with the error flag set; no bus writes are issued.
  - Otherwise go to UNLOCK.
  - Interrupt clears are never window-checked.
- **UNLOCK.** Write `addr`=`LOCK_ADDR`, `wdata`=`UNLOCK_KEY`. Go to OP.
- **OP.** For a feed, write `addr`=`LOAD_ADDR`, `wdata`=latched `reload_val`. For a clear, write `addr`=`INTCLR_ADDR`, `wdata`=32'h1. Go to LOCK.
- **LOCK.** Write `addr`=`LOCK_ADDR`, `wdata`=`LOCK_KEY`. Go to DONE.
- **DONE.** Pulse `gnt[idx]`; pulse `err[idx]` if the request was rejected. Set `ptr` = (idx+1) mod NREQ. Go to IDLE.
- `ptr` is updated only in DONE, so rejected requests also rotate priority.
- Requests are level-sensitive, and `req` is not sampled outside IDLE.
  - A requester deasserts `req` in the cycle after it sees `gnt`.
  - A request still high at that point is treated as a new request.
- Changes to `req`, `req_clr` or `reload_val` after the grant do not affect the sequence in flight.
- `addr`, `wdata` and `byte_strobe` are 0 in every cycle where `write_en` = 0.
- All outputs are registered.

## Timing
- Reset (`prestn`=1 at a clock edge) forces the following on the next cycle, including when it arrives mid-sequence:
  - state IDLE, `ptr` = 0;
  - `addr`, `wdata`, `byte_strobe`, `write_en`, `gnt`, `err` = 0 and `busy` = 0.
- An aborted sequence issues no further writes and produces no `gnt`.
- Accepted request, with `req` first seen in IDLE at cycle N:
  - unlock write at N+1, operation write at N+2, relock write at N+3;
  - `gnt` at N+4;
  - the earliest next grant decision is at N+5, giving a 5-cycle throughput.
- Rejected request: `gnt`+`err` at N+1; the next decision is at N+2.
- `write_en` is high for exactly 3 consecutive cycles per accepted request and never high for rejected requests.
- `busy` rises at N+1 and falls in the cycle after `gnt`.
- Simultaneous requests are resolved purely by `ptr` order. No requester waits longer than NREQ-1 sequences.
- Window boundary: `iwdt_value` == `win_limit` is accepted; `win_limit`+1 is rejected.

## Test plan
- **Reset.** Assert `prestn` for 2 cycles, then release with no requests -> all outputs 0, `busy`=0 and no `write_en`.
- **Single feed.** `req`=4'b0001, `req_clr`=0, `reload_val`=32'h0000_1234, `win_en`=0 -> writes (C00, 1ACCE551), (000, 00001234), (C00, 0) in 3 consecutive cycles, then `gnt`=4'b0001, `err`=0.
- **Round-robin.** `req`=4'b1011 held continuously, each `gnt`'d bit dropped the next cycle -> grant order 0, 1, 3. Re-raising `req[0]` during the sequence for 3 grants it next.
- **Window.** `win_en`=1, `win_limit`=100:
  - `iwdt_value`=101 with a feed from requester 2 -> `gnt`=`err`=4'b0100 one cycle after the request, with zero writes;
  - `iwdt_value`=100 -> normal 3-write sequence with `err`=0;
  - a clear request at `iwdt_value`=500 -> accepted.
- **Interrupt clear.** `req_clr[1]`=1 -> the middle write is (00C, 00000001).
- **Reset mid-sequence.** Assert `prestn` in the OP cycle -> no LOCK write, no `gnt`, `ptr` back to 0; a following request from requester 0 completes normally.

Source files
------------

// File: rtl/iwdt_feed_sched.sv
// Arbitrates IWDT register access among NREQ requesters and runs the locked-register
// write sequence (unlock, reload or interrupt-clear, relock) for each grant.
module iwdt_feed_sched #(
  parameter int unsigned NREQ        = 4,
  parameter logic [31:0] LOCK_ADDR   = 32'h0000_0C00,
  parameter logic [31:0] LOAD_ADDR   = 32'h0000_0000,
  parameter logic [31:0] INTCLR_ADDR = 32'h0000_000C,
  parameter logic [31:0] UNLOCK_KEY  = 32'h1ACC_E551,
  parameter logic [31:0] LOCK_KEY    = 32'h0000_0000
) (
  input  logic            pclk,
  input  logic            prestn,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_clr,
  input  logic [31:0]     reload_val,
  input  logic            win_en,
  input  logic [31:0]     win_limit,
  input  logic [31:0]     iwdt_value,
  output logic [31:0]     addr,
  output logic            write_en,
  output logic [31:0]     wdata,
  output logic [3:0]      byte_strobe,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] err,
  output logic            busy
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [2:0] {StIdle, StUnlock, StOp, StLock, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [IW-1:0]   r_ptr, w_ptr_d;
  logic [IW-1:0]   r_idx, w_idx_d;
  logic            r_clr, w_clr_d;
  logic            r_rej, w_rej_d;
  logic [31:0]     r_reload, w_reload_d;

  logic [31:0]     r_addr, w_addr_d;
  logic [31:0]     r_wdata, w_wdata_d;
  logic            r_we, w_we_d;
  logic [3:0]      r_strb, w_strb_d;
  logic [NREQ-1:0] r_gnt, w_gnt_d;
  logic [NREQ-1:0] r_err, w_err_d;
  logic            r_busy;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_cand;

  // Round-robin search: first set request at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_cand = IW'((32'(r_ptr) + i) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_ptr_d    = r_ptr;
    w_idx_d    = r_idx;
    w_clr_d    = r_clr;
    w_rej_d    = r_rej;
    w_reload_d = r_reload;
    w_addr_d   = '0;
    w_wdata_d  = '0;
    w_we_d     = 1'b0;
    w_strb_d   = '0;
    w_gnt_d    = '0;
    w_err_d    = '0;

    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_idx_d    = w_win;
          w_clr_d    = req_clr[w_win];
          w_reload_d = reload_val;
          w_rej_d    = !req_clr[w_win] && win_en && (iwdt_value > win_limit);
          w_state_d  = w_rej_d ? StDone : StUnlock;
        end
      end
      StUnlock: w_state_d = StOp;
      StOp:     w_state_d = StLock;
      StLock:   w_state_d = StDone;
      StDone: begin
        w_state_d = StIdle;
        w_ptr_d   = IW'((32'(r_idx) + 32'd1) % NREQ);
      end
      default:  w_state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    unique case (w_state_d)
      StUnlock: begin
        w_we_d    = 1'b1;
        w_strb_d  = 4'hF;
        w_addr_d  = LOCK_ADDR;
        w_wdata_d = UNLOCK_KEY;
      end
      StOp: begin
        w_we_d    = 1'b1;
        w_strb_d  = 4'hF;
        w_addr_d  = w_clr_d ? INTCLR_ADDR : LOAD_ADDR;
        w_wdata_d = w_clr_d ? 32'h1 : w_reload_d;
      end
      StLock: begin
        w_we_d    = 1'b1;
        w_strb_d  = 4'hF;
        w_addr_d  = LOCK_ADDR;
        w_wdata_d = LOCK_KEY;
      end
      StDone: begin
        w_gnt_d[w_idx_d] = 1'b1;
        w_err_d[w_idx_d] = w_rej_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (prestn) begin
      r_state  <= StIdle;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_clr    <= 1'b0;
      r_rej    <= 1'b0;
      r_reload <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_strb   <= '0;
      r_gnt    <= '0;
      r_err    <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_ptr    <= w_ptr_d;
      r_idx    <= w_idx_d;
      r_clr    <= w_clr_d;
      r_rej    <= w_rej_d;
      r_reload <= w_reload_d;
      r_addr   <= w_addr_d;
      r_wdata  <= w_wdata_d;
      r_we     <= w_we_d;
      r_strb   <= w_strb_d;
      r_gnt    <= w_gnt_d;
      r_err    <= w_err_d;
      r_busy   <= (w_state_d != StIdle);
    end
  end

  assign addr        = r_addr;
  assign wdata       = r_wdata;
  assign write_en    = r_we;
  assign byte_strobe = r_strb;
  assign gnt         = r_gnt;
  assign err         = r_err;
  assign busy        = r_busy;

endmodule
